// File: rtl/store_mailbox.sv
// Store-capture mailbox on the core data bus: stores inside an address window are queued
// with their address and drained through a valid/ready stream; control/status via the same bus.
module store_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h60,
    parameter int unsigned WINDOW    = 16,
    parameter logic [31:0] CTRL_ADDR = 32'h80,
    parameter logic [31:0] STAT_ADDR = 32'h84,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    output logic [31:0]                ReadData,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] pack_status(input logic [7:0] drops,
                                                input logic [CNT_W-1:0] cnt,
                                                input logic ovf,
                                                input logic is_full);
        logic [5:0] cnt6;
        cnt6 = 6'(cnt);
        return {16'b0, drops, cnt6, ovf, is_full};
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic [31:0] mem_addr_q [DEPTH];
    logic [31:0] mem_data_q [DEPTH];

    logic in_window, ctrl_wr, push_req, full, pop, push_ok, drop, flush, clr;

    // Window bounds are compared in 33 bits so a window ending at 2^32 does not wrap.
    always_comb begin
        in_window = ({1'b0, DataAdr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, DataAdr} <  ({1'b0, BASE_ADDR} + 33'(WINDOW)));
        ctrl_wr   = MemWrite && (DataAdr == CTRL_ADDR);
        push_req  = MemWrite && in_window && !ctrl_wr && (DataAdr != STAT_ADDR);
        full      = (count_q == CNT_W'(DEPTH));
        pop       = out_valid && out_ready;
        push_ok   = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        flush     = ctrl_wr && WriteData[1];
        clr       = ctrl_wr && WriteData[0];
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (clr) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end else if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = sat_inc8(drop_count_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage carries no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr_q[wr_ptr_q] <= DataAdr;
            mem_data_q[wr_ptr_q] <= WriteData;
        end
    end

    always_comb begin
        out_valid  = (count_q != '0);
        out_addr   = mem_addr_q[rd_ptr_q];
        out_data   = mem_data_q[rd_ptr_q];
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
        ReadData   = (DataAdr == STAT_ADDR) ?
                     pack_status(drop_count_q, count_q, overflow_q, full) : 32'h0;
    end

endmodule

// File: tb/tb_store_mailbox.sv
// Directed bench for store_mailbox: a table of per-cycle bus vectors with expected
// post-edge state, followed by saturation and asynchronous-reset sequences.
module tb_store_mailbox;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    store_mailbox dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic        v;
        logic [31:0] ea;
        logic [31:0] ed;
        int          cnt;
        logic        ov;
        int          dr;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic mw, logic [31:0] adr, logic [31:0] wd, logic rdy,
                                logic v, logic [31:0] ea, logic [31:0] ed, int cnt,
                                logic ov, int dr, logic [31:0] rd);
        vec_t t;
        t.mw = mw; t.adr = adr; t.wd = wd; t.rdy = rdy; t.v = v; t.ea = ea; t.ed = ed;
        t.cnt = cnt; t.ov = ov; t.dr = dr; t.rd = rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                        input logic rdy);
        @(negedge clk);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'h84; WriteData = 32'h0; out_ready = 1'b0;
        #12;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_count", 32'(count), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        check("reset_drops", 32'(drop_count), 32'h0);
        check("reset_status", ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        //                 mw    adr      wd      rdy   v     ea       ed     cnt ov dr rd
        vecs.push_back(mk(1'b1, 32'h61, 32'h25, 1'b0, 1'b1, 32'h61, 32'h25, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h5F, 32'h01, 1'b0, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h60, 32'h02, 1'b0, 1'b1, 32'h60, 32'h02, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h6F, 32'h03, 1'b0, 1'b1, 32'h60, 32'h02, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h70, 32'h04, 1'b0, 1'b1, 32'h60, 32'h02, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h84, 32'h00, 1'b0, 1'b1, 32'h60, 32'h02, 2, 0, 0, 32'h8));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b1, 32'h6F, 32'h03, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        // Six stores into a four-entry queue: two drops, head unchanged.
        vecs.push_back(mk(1'b1, 32'h60, 32'h10, 1'b0, 1'b1, 32'h60, 32'h10, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h61, 32'h11, 1'b0, 1'b1, 32'h60, 32'h10, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h62, 32'h12, 1'b0, 1'b1, 32'h60, 32'h10, 3, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h63, 32'h13, 1'b0, 1'b1, 32'h60, 32'h10, 4, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h64, 32'h14, 1'b0, 1'b1, 32'h60, 32'h10, 4, 1, 1, 32'h0));
        vecs.push_back(mk(1'b1, 32'h65, 32'h15, 1'b0, 1'b1, 32'h60, 32'h10, 4, 1, 2, 32'h0));
        vecs.push_back(mk(1'b0, 32'h84, 32'h00, 1'b0, 1'b1, 32'h60, 32'h10, 4, 1, 2, 32'h213));
        vecs.push_back(mk(1'b1, 32'h80, 32'h01, 1'b0, 1'b1, 32'h60, 32'h10, 4, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h84, 32'h00, 1'b0, 1'b1, 32'h60, 32'h10, 4, 0, 0, 32'h11));
        // Full queue with simultaneous push and pop.
        vecs.push_back(mk(1'b1, 32'h62, 32'hAA, 1'b1, 1'b1, 32'h61, 32'h11, 4, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b1, 32'h62, 32'h12, 3, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b1, 32'h63, 32'h13, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b1, 32'h62, 32'hAA, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        // One drop, one pop, then flush with out_ready high.
        vecs.push_back(mk(1'b1, 32'h66, 32'h20, 1'b0, 1'b1, 32'h66, 32'h20, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h67, 32'h21, 1'b0, 1'b1, 32'h66, 32'h20, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h68, 32'h22, 1'b0, 1'b1, 32'h66, 32'h20, 3, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h69, 32'h23, 1'b0, 1'b1, 32'h66, 32'h20, 4, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h6A, 32'h24, 1'b0, 1'b1, 32'h66, 32'h20, 4, 1, 1, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b1, 32'h67, 32'h21, 3, 1, 1, 32'h0));
        vecs.push_back(mk(1'b1, 32'h80, 32'h02, 1'b1, 1'b0, 32'h00, 32'h00, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1'b0, 32'h84, 32'h00, 1'b0, 1'b0, 32'h00, 32'h00, 0, 1, 1, 32'h102));
        vecs.push_back(mk(1'b1, 32'h80, 32'h03, 1'b0, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h84, 32'hFF, 1'b0, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));
        // Empty queue: push with out_ready high is queued, then streams one per cycle.
        vecs.push_back(mk(1'b1, 32'h6C, 32'h30, 1'b1, 1'b1, 32'h6C, 32'h30, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h6D, 32'h31, 1'b1, 1'b1, 32'h6D, 32'h31, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 0, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            step(vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
            check($sformatf("v%0d_drops", i), 32'(drop_count), 32'(vecs[i].dr));
            check($sformatf("v%0d_rdata", i), ReadData, vecs[i].rd);
            if (vecs[i].v) begin
                check($sformatf("v%0d_addr", i), out_addr, vecs[i].ea);
                check($sformatf("v%0d_data", i), out_data, vecs[i].ed);
            end
        end

        // drop_count saturates at 255.
        for (int k = 0; k < 4; k++) step(1'b1, 32'h60 + 32'(k), 32'h40 + 32'(k), 1'b0);
        for (int k = 0; k < 300; k++) step(1'b1, 32'h6E, 32'h99, 1'b0);
        step(1'b0, 32'h84, 32'h0, 1'b0);
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_status", ReadData, 32'hFF13);
        check("sat_head_addr", out_addr, 32'h60);
        check("sat_head_data", out_data, 32'h40);
        step(1'b1, 32'h80, 32'h3, 1'b0);
        check("clrflush_count", 32'(count), 32'h0);
        check("clrflush_drops", 32'(drop_count), 32'h0);

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 32'h63, 32'h50, 1'b0);
        step(1'b1, 32'h64, 32'h51, 1'b0);
        check("pre_areset_count", 32'(count), 32'h2);
        MemWrite = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'h0);
        check("areset_count", 32'(count), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'h84, 32'h0, 1'b0);
        check("post_areset_count", 32'(count), 32'h0);
        check("post_areset_status", ReadData, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
